// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - load-use stall, redirect flush and bypass select controller
module pipe_hazard_ctrl #(
  parameter  int REG_ADDR_W   = 5,
  parameter  int FWD_STAGES   = 2,
  parameter  int LOAD_LATENCY = 1,
  parameter  int CNT_W        = 16,
  localparam int SEL_W        = $clog2(FWD_STAGES + 1)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  dec_valid,
  input  logic [REG_ADDR_W-1:0] dec_rs,
  input  logic [REG_ADDR_W-1:0] dec_rt,
  input  logic                  dec_use_rs,
  input  logic                  dec_use_rt,
  input  logic [REG_ADDR_W-1:0] dec_dest,
  input  logic                  dec_dest_en,
  input  logic                  dec_is_load,
  input  logic                  dec_is_store,
  input  logic                  ex_redirect,
  output logic                  stall,
  output logic                  flush,
  output logic [SEL_W-1:0]      fwd_sel_a,
  output logic [SEL_W-1:0]      fwd_sel_b,
  output logic [SEL_W-1:0]      st_fwd_sel,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] dest;
    logic                  dest_en;
    logic                  is_load;
    logic                  is_store;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic                  use_rs;
    logic                  use_rt;
  } entry_t;

  // Index 0 is the D/X latch, 1..FWD_STAGES are the post-Execute stages.
  entry_t pipe_q [0:FWD_STAGES];
  entry_t pipe_d [0:FWD_STAGES];

  logic             load_hit;
  logic [SEL_W-1:0] st_k;
  logic             st_k_load;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Register 0 is hard-wired zero, so it never has a producer.
  function automatic logic is_producer(input entry_t e, input logic [REG_ADDR_W-1:0] r);
    return e.valid && e.dest_en && (e.dest == r) && (r != '0);
  endfunction

  // Detect consumers of loads whose data is not yet forwardable; store rt gets one extra stage of slack.
  always_comb begin
    load_hit = 1'b0;
    for (int p = 0; p < LOAD_LATENCY; p++) begin
      if (pipe_q[p].is_load) begin
        if (dec_use_rs && is_producer(pipe_q[p], dec_rs)) load_hit = 1'b1;
        if (dec_use_rt && !dec_is_store && is_producer(pipe_q[p], dec_rt)) load_hit = 1'b1;
        if (dec_use_rt && dec_is_store && (p < LOAD_LATENCY - 1) &&
            is_producer(pipe_q[p], dec_rt)) load_hit = 1'b1;
      end
    end
  end

  assign flush = ex_redirect;
  assign stall = dec_valid && !ex_redirect && load_hit;

  // Execute operand bypass: scanning oldest to youngest lets the youngest producer win.
  always_comb begin
    fwd_sel_a = '0;
    fwd_sel_b = '0;
    for (int k = FWD_STAGES; k >= 1; k--) begin
      if (pipe_q[0].valid && pipe_q[0].use_rs && is_producer(pipe_q[k], pipe_q[0].rs))
        fwd_sel_a = SEL_W'(k);
      if (pipe_q[0].valid && pipe_q[0].use_rt && is_producer(pipe_q[k], pipe_q[0].rt))
        fwd_sel_b = SEL_W'(k);
    end
  end

  // Late store-data bypass at stage 1; only a load as the youngest producer needs it.
  always_comb begin
    st_fwd_sel = '0;
    st_k       = '0;
    st_k_load  = 1'b0;
    for (int k = FWD_STAGES; k >= 2; k--) begin
      if (is_producer(pipe_q[k], pipe_q[1].rt)) begin
        st_k      = SEL_W'(k);
        st_k_load = pipe_q[k].is_load;
      end
    end
    if (pipe_q[1].valid && pipe_q[1].is_store && st_k_load) st_fwd_sel = st_k;
  end

  // Scoreboard next state: admit F/D into D/X unless stalled or squashed, shift the rest.
  always_comb begin
    pipe_d[0] = '0;
    if (dec_valid && !stall && !flush) begin
      pipe_d[0].valid    = 1'b1;
      pipe_d[0].dest     = dec_dest;
      pipe_d[0].dest_en  = dec_dest_en;
      pipe_d[0].is_load  = dec_is_load;
      pipe_d[0].is_store = dec_is_store;
      pipe_d[0].rs       = dec_rs;
      pipe_d[0].rt       = dec_rt;
      pipe_d[0].use_rs   = dec_use_rs;
      pipe_d[0].use_rt   = dec_use_rt;
    end
    for (int k = 1; k <= FWD_STAGES; k++) pipe_d[k] = pipe_q[k-1];
  end

  // Saturating event counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  // Scoreboard and counter registers; reset empties the pipeline at once.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k <= FWD_STAGES; k++) pipe_q[k] <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      for (int k = 0; k <= FWD_STAGES; k++) pipe_q[k] <= pipe_d[k];
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - bench for pipe_hazard_ctrl in two configurations against an age-based model
module tb_pipe_hazard_ctrl;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       dec_valid = 1'b0;
  logic [4:0] dec_rs = '0, dec_rt = '0, dec_dest = '0;
  logic       dec_use_rs = 1'b0, dec_use_rt = 1'b0, dec_dest_en = 1'b0;
  logic       dec_is_load = 1'b0, dec_is_store = 1'b0, ex_redirect = 1'b0;

  logic [1:0]  stall_v, flush_v;
  logic [3:0]  fa_v, fb_v, st_v;
  logic [31:0] sc_v, fc_v;

  always #5 clock = ~clock;

  pipe_hazard_ctrl #(.REG_ADDR_W(5), .FWD_STAGES(2), .LOAD_LATENCY(1), .CNT_W(16)) u_dut0 (
    .clock(clock), .reset_n(reset_n), .dec_valid(dec_valid), .dec_rs(dec_rs), .dec_rt(dec_rt),
    .dec_use_rs(dec_use_rs), .dec_use_rt(dec_use_rt), .dec_dest(dec_dest), .dec_dest_en(dec_dest_en),
    .dec_is_load(dec_is_load), .dec_is_store(dec_is_store), .ex_redirect(ex_redirect),
    .stall(stall_v[0]), .flush(flush_v[0]), .fwd_sel_a(fa_v[1:0]), .fwd_sel_b(fb_v[1:0]),
    .st_fwd_sel(st_v[1:0]), .stall_cnt(sc_v[15:0]), .flush_cnt(fc_v[15:0]));

  pipe_hazard_ctrl #(.REG_ADDR_W(5), .FWD_STAGES(3), .LOAD_LATENCY(2), .CNT_W(16)) u_dut1 (
    .clock(clock), .reset_n(reset_n), .dec_valid(dec_valid), .dec_rs(dec_rs), .dec_rt(dec_rt),
    .dec_use_rs(dec_use_rs), .dec_use_rt(dec_use_rt), .dec_dest(dec_dest), .dec_dest_en(dec_dest_en),
    .dec_is_load(dec_is_load), .dec_is_store(dec_is_store), .ex_redirect(ex_redirect),
    .stall(stall_v[1]), .flush(flush_v[1]), .fwd_sel_a(fa_v[3:2]), .fwd_sel_b(fb_v[3:2]),
    .st_fwd_sel(st_v[3:2]), .stall_cnt(sc_v[31:16]), .flush_cnt(fc_v[31:16]));

  // Model: every admitted instruction is remembered with the cycle it sat in D/X; its age is its position.
  typedef struct {
    int         cfg;
    int         t;
    logic [4:0] dest, rs, rt;
    logic       dest_en, is_load, is_store, use_rs, use_rt;
  } rec_t;

  rec_t inflight[$];
  int   cyc = 0;
  int   m_sc[2] = '{0, 0};
  int   m_fc[2] = '{0, 0};
  int   last_stall[2], last_flush[2], last_fa[2], last_fb[2], last_st[2];
  int   n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int fs(input int c); return (c != 0) ? 3 : 2; endfunction
  function automatic int ll(input int c); return (c != 0) ? 2 : 1; endfunction

  function automatic bit writes(input rec_t e, input logic [4:0] r);
    return e.dest_en && (e.dest == r) && (r != 5'd0);
  endfunction

  function automatic int rec_at(input int c, input int p);
    for (int i = 0; i < inflight.size(); i++)
      if (inflight[i].cfg == c && (cyc - inflight[i].t) == p) return i;
    return -1;
  endfunction

  // Nearest position in lo..hi holding a writer of r, or 0 when there is none.
  function automatic int nearest(input int c, input logic [4:0] r, input int lo, input int hi);
    for (int p = lo; p <= hi; p++) begin
      int i = rec_at(c, p);
      if (i >= 0 && writes(inflight[i], r)) return p;
    end
    return 0;
  endfunction

  function automatic bit young_load(input int c, input logic [4:0] r, input int lim);
    for (int p = 0; p < lim; p++) begin
      int i = rec_at(c, p);
      if (i >= 0 && inflight[i].is_load && writes(inflight[i], r)) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic bit exp_stall(input int c);
    if (!dec_valid || ex_redirect) return 1'b0;
    if (dec_use_rs && young_load(c, dec_rs, ll(c))) return 1'b1;
    if (dec_use_rt && !dec_is_store && young_load(c, dec_rt, ll(c))) return 1'b1;
    if (dec_use_rt && dec_is_store && young_load(c, dec_rt, ll(c) - 1)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int exp_fwd(input int c, input bit use_b);
    int i = rec_at(c, 0);
    if (i < 0) return 0;
    if (!use_b) return inflight[i].use_rs ? nearest(c, inflight[i].rs, 1, fs(c)) : 0;
    return inflight[i].use_rt ? nearest(c, inflight[i].rt, 1, fs(c)) : 0;
  endfunction

  function automatic int exp_st(input int c);
    int i = rec_at(c, 1);
    int k;
    if (i < 0 || !inflight[i].is_store) return 0;
    k = nearest(c, inflight[i].rt, 2, fs(c));
    if (k == 0) return 0;
    return inflight[rec_at(c, k)].is_load ? k : 0;
  endfunction

  // True unless sel points at a load still too young to forward.
  function automatic bit sel_safe(input int c, input int k);
    int i;
    if (k == 0) return 1'b1;
    i = rec_at(c, k);
    if (i < 0) return 1'b1;
    return !(inflight[i].is_load && k < ll(c) + 1);
  endfunction

  task automatic step(input logic v, input logic [4:0] rs, input logic urs, input logic [4:0] rt,
                      input logic urt, input logic [4:0] dst, input logic den, input logic ld,
                      input logic st, input logic redir);
    bit es[2];
    int i0;
    dec_valid = v; dec_rs = rs; dec_use_rs = urs; dec_rt = rt; dec_use_rt = urt;
    dec_dest = dst; dec_dest_en = den; dec_is_load = ld; dec_is_store = st; ex_redirect = redir;
    #4;
    for (int c = 0; c < 2; c++) begin
      es[c] = exp_stall(c);
      last_stall[c] = int'(stall_v[c]);
      last_flush[c] = int'(flush_v[c]);
      last_fa[c] = int'(fa_v[c*2 +: 2]);
      last_fb[c] = int'(fb_v[c*2 +: 2]);
      last_st[c] = int'(st_v[c*2 +: 2]);
      check($sformatf("stall c%0d cyc%0d", c, cyc), 32'(stall_v[c]), 32'(es[c]));
      check($sformatf("flush c%0d cyc%0d", c, cyc), 32'(flush_v[c]), 32'(redir));
      check($sformatf("fwd_a c%0d cyc%0d", c, cyc), 32'(fa_v[c*2 +: 2]), 32'(exp_fwd(c, 1'b0)));
      check($sformatf("fwd_b c%0d cyc%0d", c, cyc), 32'(fb_v[c*2 +: 2]), 32'(exp_fwd(c, 1'b1)));
      check($sformatf("st_fwd c%0d cyc%0d", c, cyc), 32'(st_v[c*2 +: 2]), 32'(exp_st(c)));
      check($sformatf("stall_cnt c%0d cyc%0d", c, cyc), 32'(sc_v[c*16 +: 16]), 32'(m_sc[c]));
      check($sformatf("flush_cnt c%0d cyc%0d", c, cyc), 32'(fc_v[c*16 +: 16]), 32'(m_fc[c]));
      check($sformatf("inv_a c%0d cyc%0d", c, cyc), 32'(sel_safe(c, int'(fa_v[c*2 +: 2]))), 32'd1);
      i0 = rec_at(c, 0);
      if (i0 >= 0 && !inflight[i0].is_store)
        check($sformatf("inv_b c%0d cyc%0d", c, cyc), 32'(sel_safe(c, int'(fb_v[c*2 +: 2]))), 32'd1);
    end
    @(posedge clock);
    cyc++;
    for (int c = 0; c < 2; c++) begin
      if (es[c] && m_sc[c] < 65535) m_sc[c]++;
      if (redir && m_fc[c] < 65535) m_fc[c]++;
      if (v && !es[c] && !redir)
        inflight.push_back('{cfg: c, t: cyc, dest: dst, rs: rs, rt: rt, dest_en: den,
                             is_load: ld, is_store: st, use_rs: urs, use_rt: urt});
    end
    for (int i = inflight.size() - 1; i >= 0; i--)
      if (cyc - inflight[i].t > fs(inflight[i].cfg)) inflight.delete(i);
    #1;
  endtask

  task automatic i_alu(input int d, input int s, input int t);
    step(1'b1, 5'(s), 1'b1, 5'(t), 1'b1, 5'(d), 1'b1, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic i_lw(input int d, input int b);
    step(1'b1, 5'(b), 1'b1, 5'd0, 1'b0, 5'(d), 1'b1, 1'b1, 1'b0, 1'b0);
  endtask
  task automatic i_sw(input int t, input int b);
    step(1'b1, 5'(b), 1'b1, 5'(t), 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask
  task automatic i_nop;
    step(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Asserts reset between edges with the current inputs still applied, then releases it.
  task automatic do_reset;
    #2 reset_n = 1'b0;
    #1;
    for (int c = 0; c < 2; c++) begin
      check($sformatf("rst_stall c%0d", c), 32'(stall_v[c]), 32'd0);
      check($sformatf("rst_flush c%0d", c), 32'(flush_v[c]), 32'(ex_redirect));
      check($sformatf("rst_sel c%0d", c), 32'({fa_v[c*2 +: 2], fb_v[c*2 +: 2], st_v[c*2 +: 2]}), 32'd0);
      check($sformatf("rst_cnt c%0d", c), sc_v[c*16 +: 16] | fc_v[c*16 +: 16], 32'd0);
      m_sc[c] = 0;
      m_fc[c] = 0;
    end
    inflight.delete();
    dec_valid = 1'b0;
    ex_redirect = 1'b0;
    @(posedge clock);
    #3 reset_n = 1'b1;
    @(posedge clock);
    cyc++;
    #1;
  endtask

  logic       r_ld, r_st;
  int         r_k;

  initial begin
    @(posedge clock);
    #1;
    do_reset;

    // Load-use, default configuration.
    i_lw(5, 4);
    i_alu(6, 5, 7);  check("lu_stall0", 32'(last_stall[0]), 32'd1);
    i_alu(6, 5, 7);  check("lu_release0", 32'(last_stall[0]), 32'd0);
    i_nop;           check("lu_fwd0", 32'(last_fa[0]), 32'd2);
    check("lu_cnt0", 32'(sc_v[15:0]), 32'd1);

    // ALU back-to-back and with one NOP between.
    do_reset;
    i_alu(3, 1, 2); i_alu(4, 3, 3); i_nop;
    check("alu_fa1", 32'(last_fa[0]), 32'd1);
    check("alu_fb1", 32'(last_fb[0]), 32'd1);
    i_alu(3, 1, 2); i_nop; i_alu(4, 3, 3); i_nop;
    check("alu_fa2", 32'(last_fa[0]), 32'd2);
    check("alu_fb2", 32'(last_fb[0]), 32'd2);

    // Load followed by store of the loaded register.
    do_reset;
    i_lw(8, 4); i_sw(8, 9);
    check("ls_nostall0", 32'(last_stall[0]), 32'd0);
    i_nop; i_nop;
    check("ls_stfwd0", 32'(last_st[0]), 32'd2);

    // Redirect coinciding with a load-use hazard.
    do_reset;
    i_lw(5, 4);
    step(1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1);
    check("rd_stall0", 32'(last_stall[0]), 32'd0);
    check("rd_flush0", 32'(last_flush[0]), 32'd1);
    i_nop;
    check("rd_bubble0", 32'(last_fa[0]), 32'd0);
    check("rd_cnt0", 32'(fc_v[15:0]), 32'd1);

    // Register 0 never stalls or forwards.
    do_reset;
    i_alu(0, 1, 2); i_alu(5, 0, 0);
    check("r0_stall", 32'(last_stall[0]), 32'd0);
    i_nop;
    check("r0_sel", 32'(last_fa[0] + last_fb[0]), 32'd0);
    i_lw(0, 4); i_alu(6, 0, 0);
    check("r0_lstall", 32'(last_stall[0] + last_stall[1]), 32'd0);

    // Deeper configuration: two-cycle load latency.
    do_reset;
    i_lw(5, 4);
    i_alu(6, 5, 7); check("d_stall_a", 32'(last_stall[1]), 32'd1);
    i_alu(6, 5, 7); check("d_stall_b", 32'(last_stall[1]), 32'd1);
    i_alu(6, 5, 7); check("d_release", 32'(last_stall[1]), 32'd0);
    i_nop;          check("d_fwd3", 32'(last_fa[1]), 32'd3);
    check("d_cnt", 32'(sc_v[31:16]), 32'd2);

    do_reset;
    i_lw(5, 4);
    i_sw(5, 9); check("d_st_stall", 32'(last_stall[1]), 32'd1);
    i_sw(5, 9); check("d_st_release", 32'(last_stall[1]), 32'd0);
    i_nop; i_nop;
    check("d_stfwd3", 32'(last_st[1]), 32'd3);

    // Reset in the middle of a stall.
    do_reset;
    i_lw(5, 4); i_alu(6, 5, 7);
    check("pre_rst_stall1", 32'(stall_v[1]), 32'd1);
    do_reset;

    // Randomized traffic over a small register set to provoke hazards.
    repeat (600) begin
      if ($urandom_range(0, 149) == 0) do_reset;
      r_k  = $urandom_range(0, 9);
      r_ld = (r_k < 3);
      r_st = (r_k == 3 || r_k == 4);
      step(1'($urandom_range(0, 99) < 85), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
           5'($urandom_range(0, 3)), r_st ? 1'b1 : 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 3)), r_st ? 1'b0 : 1'($urandom_range(0, 4) != 0),
           r_ld, r_st, 1'($urandom_range(0, 99) < 8));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal;
  end

endmodule
